// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display multiplexer: segment patterns
// ({g,f,e,d,c,b,a}, active-low), digit slot indices and the all-off anode value.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] IDX_SEC_ONES = 2'd0;
    localparam logic [1:0] IDX_SEC_TENS = 2'd1;
    localparam logic [1:0] IDX_MIN_ONES = 2'd2;
    localparam logic [1:0] IDX_MIN_TENS = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode enable for a digit slot.
    function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; codes 10-15 render as a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Segment lookup for one BCD digit.
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit common-anode display multiplexer with frame snapshot and adjust blink.
// Optional macro SEG_DISPLAY_MUX_LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min_first_dig,
    input  logic [3:0] min_second_dig,
    input  logic [3:0] sec_first_dig,
    input  logic [3:0] sec_second_dig,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt_r;
    logic [1:0]    idx_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;
    logic [3:0]    snap_min_first_r;
    logic [3:0]    snap_min_second_r;
    logic [3:0]    snap_sec_first_r;
    logic [3:0]    snap_sec_second_r;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          dp_r;

    logic          refresh_wrap_s;
    logic          blink_wrap_s;
    logic [3:0]    digit_s;
    logic [6:0]    seg_dec_s;
    logic          blank_s;

    assign refresh_wrap_s = (refresh_cnt_r == REFRESH_LAST);
    assign blink_wrap_s   = (blink_cnt_r == BLINK_LAST);

    // Refresh counter and digit scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_r <= {RW{1'b0}};
            idx_r         <= IDX_SEC_ONES;
        end else if (refresh_wrap_s) begin
            refresh_cnt_r <= {RW{1'b0}};
            idx_r         <= idx_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + RW'(1);
        end
    end

    // Free-running blink timebase, independent of adjust mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_wrap_s) begin
            blink_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BW'(1);
        end
    end

    // Capture all digits only at the frame boundary so a frame never mixes two times.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_min_first_r  <= 4'd0;
            snap_min_second_r <= 4'd0;
            snap_sec_first_r  <= 4'd0;
            snap_sec_second_r <= 4'd0;
        end else if (refresh_wrap_s && (idx_r == IDX_MIN_TENS)) begin
            snap_min_first_r  <= min_first_dig;
            snap_min_second_r <= min_second_dig;
            snap_sec_first_r  <= sec_first_dig;
            snap_sec_second_r <= sec_second_dig;
        end else begin
            snap_min_first_r  <= snap_min_first_r;
            snap_min_second_r <= snap_min_second_r;
            snap_sec_first_r  <= snap_sec_first_r;
            snap_sec_second_r <= snap_sec_second_r;
        end
    end

    // Select the snapshot digit for the active slot.
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            IDX_SEC_ONES: digit_s = snap_sec_second_r;
            IDX_SEC_TENS: digit_s = snap_sec_first_r;
            IDX_MIN_ONES: digit_s = snap_min_second_r;
            IDX_MIN_TENS: digit_s = snap_min_first_r;
            default:      digit_s = 4'd0;
        endcase
    end

    bcd_to_seg u_dec (
        .digit (digit_s),
        .seg   (seg_dec_s)
    );

    // Blanking: blinking adjust pair, plus optional leading-zero suppression.
    always_comb begin
        blank_s = 1'b0;
        if (adj && blink_phase_r) begin
            if (sel) begin
                blank_s = (idx_r == IDX_SEC_ONES) || (idx_r == IDX_SEC_TENS);
            end else begin
                blank_s = (idx_r == IDX_MIN_ONES) || (idx_r == IDX_MIN_TENS);
            end
        end else begin
            blank_s = 1'b0;
        end
`ifdef SEG_DISPLAY_MUX_LEADING_ZERO_BLANK_EN
        if ((idx_r == IDX_MIN_TENS) && (snap_min_first_r == 4'd0)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = blank_s;
        end
`endif
    end

    // Registered display drive; dark while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else if (blank_s) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_for_idx(idx_r);
            seg_r <= seg_dec_s;
            dp_r  <= (idx_r == IDX_MIN_ONES) ? 1'b0 : 1'b1;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux with REFRESH_DIV=4, BLINK_DIV=8.
module tb_seg_display_mux;

    localparam int R = 4;
    localparam int B = 8;
    localparam int FRAME = 4 * R;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] exp_seg;
    } dec_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] min_first_dig = 4'd0;
    logic [3:0] min_second_dig = 4'd0;
    logic [3:0] sec_first_dig = 4'd0;
    logic [3:0] sec_second_dig = 4'd0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int vectors = 0;
    int miscompares = 0;
    int j = 0;
    int last_j = 0;
    logic [3:0] snap [4];
    logic [6:0] pat [16];
    dec_vec_t   dec_tab [16];

    seg_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk(clk), .rst(rst),
        .min_first_dig(min_first_dig), .min_second_dig(min_second_dig),
        .sec_first_dig(sec_first_dig), .sec_second_dig(sec_second_dig),
        .adj(adj), .sel(sel), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v,
                         input logic [11:0] mask);
        vectors++;
        if ((act & mask) !== (exp_v & mask)) begin
            miscompares++;
            $display("FAIL %s j=%0d: got an/seg/dp=%b_%b_%b want %b_%b_%b (mask %h)", name, last_j,
                     act[11:8], act[7:1], act[0], exp_v[11:8], exp_v[7:1], exp_v[0], mask);
        end
    endtask

    // One clock: predict from the model, step, compare, advance the model.
    task automatic cycle(input string name);
        logic [11:0] e;
        logic [11:0] m;
        logic [3:0]  a;
        logic [3:0]  d;
        int idx;
        int phase;
        logic bl;
        e = 12'hFFF;
        m = 12'hFFF;
        last_j = j;
        if (!rst) begin
            idx   = (j / R) % 4;
            phase = (j / B) % 2;
            d     = snap[idx];
            bl    = adj && (phase == 1) && (sel ? (idx < 2) : (idx >= 2));
`ifdef SEG_DISPLAY_MUX_LEADING_ZERO_BLANK_EN
            if (idx == 3 && d == 4'd0) bl = 1'b1;
`endif
            if (bl) begin
                e = {4'b1111, 7'b0000000, 1'b1};
                m = {4'b1111, 7'b0000000, 1'b1};
            end else begin
                a = 4'b0001 << idx;
                e = {~a, pat[d], (idx == 2) ? 1'b0 : 1'b1};
            end
            if (j % FRAME == FRAME - 1) begin
                snap[0] = sec_second_dig;
                snap[1] = sec_first_dig;
                snap[2] = min_second_dig;
                snap[3] = min_first_dig;
            end
        end
        @(posedge clk);
        #1;
        check(name, {an, seg, dp}, e, m);
        if (rst) begin
            j = 0;
            for (int k = 0; k < 4; k++) snap[k] = 4'd0;
        end else begin
            j++;
        end
    endtask

    task automatic run(input string name, input int n);
        for (int i = 0; i < n; i++) cycle(name);
    endtask

    task automatic set_digits(input logic [15:0] v);
        min_first_dig  = v[15:12];
        min_second_dig = v[11:8];
        sec_first_dig  = v[7:4];
        sec_second_dig = v[3:0];
    endtask

    initial begin
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        for (int k = 0; k < 16; k++) begin
            dec_tab[k].dig     = 4'(k);
            dec_tab[k].exp_seg = (k < 10) ? pat[k] : 7'b0111111;
        end
        for (int k = 0; k < 4; k++) snap[k] = 4'd0;

        // Reset held three cycles, then the scan opens on idx0 showing 0.
        rst = 1'b1;
        run("reset", 3);
        rst = 1'b0;
        set_digits(16'h1234);
        cycle("first_after_reset");
        check("first_an_seg", {an, seg}, {4'b1110, 7'b1000000}, 11'h7FF);

        // Scan 1234, with a mid-frame change to 5678 that must not tear.
        run("scan", FRAME + R);
        set_digits(16'h5678);
        run("tearing", 2 * FRAME);

        // Blink on the seconds pair, then on the minutes pair.
        adj = 1'b1; sel = 1'b1;
        run("blink_sec", 4 * FRAME);
        sel = 1'b0;
        run("blink_min", 4 * FRAME);
        adj = 1'b0;

        // Decoder table on the idx0 slot, including invalid codes.
        for (int t = 0; t < 16; t++) begin
            set_digits({4'd1, 4'd2, 4'd3, dec_tab[t].dig});
            for (int i = 0; i < 2 * FRAME; i++) begin
                cycle("decode_stream");
                if (i >= 1 && (last_j % FRAME) == 0) begin
                    check("decode_tab", {5'd0, seg}, {5'd0, dec_tab[t].exp_seg}, 12'h07F);
                    break;
                end
            end
        end

        // Leading zero in minutes tens (blanked only with the optional macro).
        set_digits(16'h0959);
        run("min_tens_zero", 2 * FRAME);
        set_digits(16'h1959);
        run("min_tens_one", 2 * FRAME);

        // Reset mid-scan then randomized traffic with occasional resets.
        rst = 1'b1;
        cycle("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_digits(16'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                adj = 1'($urandom);
                sel = 1'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
            cycle("random");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Downstream consumer of the stopwatch counter's four BCD digits (min tens, min ones, sec tens, sec ones).
- Time-multiplexes the digits onto a common-anode 4-digit seven-segment display.
- In adjust mode, blinks the digit pair currently selected for adjustment.
- Runs on the fast system clock; one digit is active at a time, refreshed at a fixed divided rate.

Parameters:
- REFRESH_DIV, 100000: system clocks each digit stays active (100 MHz gives a 1 kHz digit rate). Must be >= 2.
- BLINK_DIV, 25000000: system clocks per blink phase toggle (2 Hz blink at 100 MHz). Must be >= 2.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- min_first_dig  input  4  minutes tens, BCD.
- min_second_dig  input  4  minutes ones, BCD.
- sec_first_dig  input  4  seconds tens, BCD.
- sec_second_dig  input  4  seconds ones, BCD.
- adj  input  1  adjust mode active.
- sel  input  1  adjust target: 0 = minutes pair, 1 = seconds pair.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low; an[3] is leftmost (min tens).
- dp  output  1  decimal point, active-low.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Every register updates only on posedge clk.
- Reset values:
  - refresh counter 0, digit index idx 0, blink counter 0, blink_phase 0, snapshot registers all 0.
  - Outputs held at an=4'b1111, seg=7'b1111111, dp=1 (display dark) while rst is high.
- Refresh counter:
  - Increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0.
- Index mapping: idx0 = sec_second, idx1 = sec_first, idx2 = min_second, idx3 = min_first.
- Snapshot (prevents tearing mid-frame):
  - All four digit inputs are captured into snapshot registers in the cycle where idx==3 and the refresh counter wraps.
  - Display uses snapshot values only. The first frame after reset shows 0000.
- Output registration, one-cycle latency:
  - an/seg/dp in cycle t+1 reflect idx and snapshot at cycle t.
  - Each digit is therefore active for exactly REFRESH_DIV consecutive cycles.
- an: exactly one bit low (bit idx), except when the digit is blanked, in which case an=4'b1111.
- Decode (seg patterns):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10–15 show dash 0111111 (no X, no blank).
- dp: 0 when idx==2 (separator after minutes), else 1. Blink blanking also forces dp=1.
- Blink:
  - Blink counter wraps at BLINK_DIV-1; blink_phase toggles on each wrap.
  - Counter runs regardless of adj, so blink is free-running.
- Blanking: when adj==1 and blink_phase==1, digits of the selected pair are blanked.
  - sel=0 blanks idx3, idx2.
  - sel=1 blanks idx1, idx0.
- adj, sel: sampled live every cycle (not snapshotted). A change takes effect on the next output update.
- Reset mid-scan: all state returns to reset values on the next edge. The scan restarts at idx0 one cycle after rst falls.

Optional Feature:
- Macro: SEG_DISPLAY_MUX_LEADING_ZERO_BLANK_EN
- Defined: when idx==3 and snapshot min_first_dig==0, that digit is blanked (an=4'b1111 for that slot). Other digits are unaffected, and a nonzero value displays normally.
- Undefined: min tens always displays, including 0.

Decomposition:
- Shared package seg_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - digit index constants IDX_SEC_ONES..IDX_MIN_TENS;
  - AN_OFF constant.
- One sub-module, bcd_to_seg: purely combinational 4-bit to 7-bit decoder, instantiated once on the muxed snapshot digit.
- Counters, snapshot, blink and output registers stay in seg_display_mux.

Test Plan (REFRESH_DIV=4, BLINK_DIV=8):
- Reset: rst high 3 cycles → an=1111, seg=1111111, dp=1. First cycle after release → an=1110, seg=1000000.
- Scan: digits 1,2,3,4 (min_first..sec_second) held → after first frame wrap, an cycles 1110/1101/1011/0111 every 4 cycles with seg 4,3,2,1 patterns; dp=0 only while an=1011.
- Tearing: change inputs from 1234 to 5678 mid-frame (idx==1) → remainder of frame still shows 1234; 5678 appears from next idx0.
- Blink: adj=1, sel=1 → idx0/idx1 slots show an=1111 during blink_phase=1 (8-cycle windows), normal in phase 0; minutes unaffected. sel=0 blanks idx2/idx3, dp=1 there.
- Invalid digit: sec_second_dig=4'hC → slot shows 0111111.
- Optional macro defined: min_first_dig=0 → idx3 slot an=1111; min_first_dig=1 → 1111001 shown.
